// File: rtl/registro_datos_pkg.sv
// -----------------------------------------------------------------------------
// registro_datos_pkg
// Shared constants and helpers for the multi-channel UART data register.
//   REGDAT_DATA_W / REGDAT_N_CH / REGDAT_DEPTH : default parameter values
//   REGDAT_MAX_CH                              : upper bound on writer channels
//   gnt_vec_t                                  : one-hot grant vector, max width
//   clog2_safe()                               : $clog2 that never returns 0
// -----------------------------------------------------------------------------
package registro_datos_pkg;

   localparam int REGDAT_DATA_W = 8;
   localparam int REGDAT_N_CH   = 2;
   localparam int REGDAT_DEPTH  = 4;
   localparam int REGDAT_MAX_CH = 8;

   typedef logic [REGDAT_MAX_CH-1:0] gnt_vec_t;

   // Index width for n items; a single channel still needs a 1-bit index.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/registro_datos_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating start pointer.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   req            : request vector (one bit per channel)
//   enable         : grants are only issued while high
//   gnt            : one-hot grant (all zero when nothing granted)
//   gnt_idx        : binary index of the granted channel
// The search begins at the pointer and wraps modulo N_CH; after a grant the
// pointer moves to the channel just past the winner, otherwise it holds.
// -----------------------------------------------------------------------------
module rr_arbiter
   import registro_datos_pkg::*;
#(
   parameter  int N_CH  = REGDAT_N_CH,
   localparam int IDX_W = clog2_safe(N_CH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [N_CH-1:0]  req,
   input  logic             enable,
   output logic [N_CH-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             found;
   int               c;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      ptr_d   = ptr_q;
      c       = 0;
      for (int k = 0; k < N_CH; k++) begin
         c = int'(ptr_q) + k;
         if (c >= N_CH) c = c - N_CH;
         if (enable && !found && req[c]) begin
            found   = 1'b1;
            gnt[c]  = 1'b1;
            gnt_idx = IDX_W'(c);
            ptr_d   = (c == N_CH - 1) ? '0 : IDX_W'(c + 1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/registro_datos_arb.sv
// -----------------------------------------------------------------------------
// registro_datos_arb
// N_CH writer channels post words into per-channel holding registers; a
// round-robin arbiter moves them into a DEPTH-entry first-word-fall-through
// FIFO that drains to the UART transmitter over valid/ready.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   data_i, we_i   : channel i word at [i*DATA_W +: DATA_W] and its strobe
//   busy_o         : holding register i occupied
//   drop_o         : one-cycle pulse, write on channel i discarded
//   data_o,valid_o : FIFO head word / FIFO non-empty
//   ready_i        : consumer accepts the head this cycle
//   last_o         : last word pushed into the FIFO
//   count_o,full_o : FIFO occupancy / occupancy == DEPTH
//   parity_o       : even parity of the head word (REGDAT_PARITY_EN only)
// Build option: define REGDAT_PARITY_EN to store a parity bit per entry.
// -----------------------------------------------------------------------------
module registro_datos_arb
   import registro_datos_pkg::*;
#(
   parameter  int DATA_W = REGDAT_DATA_W,
   parameter  int N_CH   = REGDAT_N_CH,
   parameter  int DEPTH  = REGDAT_DEPTH,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int IDX_W  = clog2_safe(N_CH)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [N_CH*DATA_W-1:0] data_i,
   input  logic [N_CH-1:0]        we_i,
   output logic [N_CH-1:0]        busy_o,
   output logic [N_CH-1:0]        drop_o,
   output logic [DATA_W-1:0]      data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [DATA_W-1:0]      last_o,
   output logic [CNT_W-1:0]       count_o,
   output logic                   full_o
`ifdef REGDAT_PARITY_EN
   ,
   output logic                   parity_o
`endif
);

`ifdef REGDAT_PARITY_EN
   localparam int ENT_W = DATA_W + 1;
`else
   localparam int ENT_W = DATA_W;
`endif

   logic [DATA_W-1:0] hold_q [N_CH];
   logic [DATA_W-1:0] hold_d [N_CH];
   logic [N_CH-1:0]   busy_q, busy_d, drop_q, drop_d;
   logic [N_CH-1:0]   gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic              push, pop;
   logic [DATA_W-1:0] push_word;
   logic [ENT_W-1:0]  push_entry, head;
   logic [ENT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [DATA_W-1:0] last_q;

   // Disabling the arbiter while full is what blocks a push even when a pop
   // frees a slot in the same cycle; the held word goes in one cycle later.
   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .req     (busy_q),
      .enable  (~full_o),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign valid_o   = (count_q != '0);
   assign push      = |gnt;
   assign pop       = valid_o & ready_i;
   assign push_word = hold_q[gnt_idx];

`ifdef REGDAT_PARITY_EN
   assign push_entry = {^push_word, push_word};
`else
   assign push_entry = push_word;
`endif

   // A write is accepted into an empty slot, or into the slot being granted
   // this cycle (its old word leaves as the new one arrives).
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         hold_d[i] = hold_q[i];
         busy_d[i] = busy_q[i];
         drop_d[i] = 1'b0;
         if (we_i[i]) begin
            if (!busy_q[i] || gnt[i]) begin
               hold_d[i] = data_i[i*DATA_W +: DATA_W];
               busy_d[i] = 1'b1;
            end else begin
               drop_d[i] = 1'b1;
            end
         end else if (gnt[i]) begin
            busy_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         busy_q <= '0;
         drop_q <= '0;
         for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
      end else begin
         busy_q <= busy_d;
         drop_q <= drop_d;
         for (int i = 0; i < N_CH; i++) hold_q[i] <= hold_d[i];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            last_q   <= push_word;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array has no reset; stale entries are never visible
   // because the head outputs are forced to zero whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= push_entry;
   end

   assign head    = mem[rd_ptr_q];
   assign data_o  = valid_o ? head[DATA_W-1:0] : '0;
   assign busy_o  = busy_q;
   assign drop_o  = drop_q;
   assign last_o  = last_q;
   assign count_o = count_q;

`ifdef REGDAT_PARITY_EN
   assign parity_o = valid_o ? head[DATA_W] : 1'b0;
`endif

endmodule

// File: tb/tb_registro_datos_arb.sv
// -----------------------------------------------------------------------------
// tb_registro_datos_arb
// Directed scenarios plus a randomized run for registro_datos_arb, compared
// against a transaction-level model built from queues and plain arithmetic.
// -----------------------------------------------------------------------------
module tb_registro_datos_arb;

   localparam int DATA_W = 8;
   localparam int N_CH   = 2;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic                   clk = 1'b0;
   logic                   reset_i;
   logic [N_CH*DATA_W-1:0] data_i;
   logic [N_CH-1:0]        we_i;
   logic [N_CH-1:0]        busy_o, drop_o;
   logic [DATA_W-1:0]      data_o, last_o;
   logic                   valid_o, ready_i, full_o;
   logic [CNT_W-1:0]       count_o;
`ifdef REGDAT_PARITY_EN
   logic                   parity_o;
`endif

   always #5 clk = ~clk;

   registro_datos_arb #(.DATA_W(DATA_W), .N_CH(N_CH), .DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .data_i  (data_i),
      .we_i    (we_i),
      .busy_o  (busy_o),
      .drop_o  (drop_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .last_o  (last_o),
      .count_o (count_o),
      .full_o  (full_o)
`ifdef REGDAT_PARITY_EN
      ,
      .parity_o(parity_o)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   logic [DATA_W-1:0] m_hold [N_CH];
   logic [N_CH-1:0]   m_busy, m_drop;
   logic [DATA_W-1:0] m_q [$];
   logic [DATA_W-1:0] m_last;
   int                m_ptr;

   task automatic m_reset();
      m_q.delete();
      for (int i = 0; i < N_CH; i++) m_hold[i] = '0;
      m_busy = '0;
      m_drop = '0;
      m_last = '0;
      m_ptr  = 0;
   endtask

   task automatic m_edge();
      int g;
      logic [DATA_W-1:0] w;
      g = -1;
      if (m_q.size() < DEPTH)
         for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (m_ptr + k) % N_CH;
            if (g < 0 && m_busy[c]) g = c;
         end
      if (m_q.size() > 0 && ready_i) void'(m_q.pop_front());
      if (g >= 0) begin
         w = m_hold[g];
         m_q.push_back(w);
         m_last = w;
         m_ptr  = (g + 1) % N_CH;
      end
      for (int i = 0; i < N_CH; i++) begin
         m_drop[i] = 1'b0;
         if (we_i[i]) begin
            if (!m_busy[i] || i == g) begin
               m_hold[i] = data_i[i*DATA_W +: DATA_W];
               m_busy[i] = 1'b1;
            end else begin
               m_drop[i] = 1'b1;
            end
         end else if (i == g) begin
            m_busy[i] = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_i) m_reset();
      else         m_edge();
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [DATA_W-1:0] v);
      data_i[ch*DATA_W +: DATA_W] = v;
   endtask

   task automatic do_reset();
      we_i    = '0;
      ready_i = 1'b0;
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
      n_checks++; if (count_o !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_o); end
      n_checks++; if (last_o !== '0) begin n_fail++; $display("FAIL reset_last got=%h exp=00", last_o); end
      n_checks++; if (busy_o !== '0) begin n_fail++; $display("FAIL reset_busy got=%b exp=00", busy_o); end
      n_checks++; if (data_o !== '0 || full_o !== 1'b0 || drop_o !== '0) begin
         n_fail++; $display("FAIL reset_misc data=%h full=%b drop=%b exp 00/0/00", data_o, full_o, drop_o);
      end
   endtask

   task automatic test_single();
      ready_i = 1'b1;
      set_ch(0, 8'hA5); we_i = 2'b01;
      tick();
      we_i = '0;
      n_checks++; if (busy_o !== 2'b01) begin n_fail++; $display("FAIL single_busy got=%b exp=01", busy_o); end
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", valid_o); end
      tick();
      n_checks++; if (valid_o !== 1'b1 || data_o !== 8'hA5) begin
         n_fail++; $display("FAIL single_head valid=%b data=%h exp 1/a5", valid_o, data_o);
      end
      n_checks++; if (last_o !== 8'hA5) begin n_fail++; $display("FAIL single_last got=%h exp=a5", last_o); end
      n_checks++; if (busy_o !== 2'b00) begin n_fail++; $display("FAIL single_busy_clr got=%b exp=00", busy_o); end
      tick();
      n_checks++; if (valid_o !== 1'b0 || count_o !== '0) begin
         n_fail++; $display("FAIL single_popped valid=%b count=%0d exp 0/0", valid_o, count_o);
      end
      ready_i = 1'b0;
   endtask

   task automatic drain_expect(input string name, input logic [DATA_W-1:0] exp_q [$]);
      ready_i = 1'b1;
      foreach (exp_q[j]) begin
         n_checks++; if (valid_o !== 1'b1 || data_o !== exp_q[j]) begin
            n_fail++; $display("FAIL %s[%0d] valid=%b data=%h exp 1/%h", name, j, valid_o, data_o, exp_q[j]);
         end
         tick();
      end
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_empty valid=%b exp=0", name, valid_o); end
      ready_i = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      set_ch(0, 8'h11); set_ch(1, 8'h22); we_i = 2'b11;
      tick(); we_i = '0; tick(); tick();
      n_checks++; if (count_o !== 3'd2 || data_o !== 8'h11) begin
         n_fail++; $display("FAIL simul_first count=%0d data=%h exp 2/11", count_o, data_o);
      end
      set_ch(0, 8'h33); set_ch(1, 8'h44); we_i = 2'b11;
      tick(); we_i = '0; tick(); tick();
      n_checks++; if (count_o !== 3'd4 || full_o !== 1'b1) begin
         n_fail++; $display("FAIL simul_full count=%0d full=%b exp 4/1", count_o, full_o);
      end
      drain_expect("simul_order", '{8'h11, 8'h22, 8'h33, 8'h44});
      // ch1-only grant leaves the pointer at 0, so ch0 wins the next tie
      set_ch(1, 8'h55); we_i = 2'b10; tick(); we_i = '0; tick();
      set_ch(0, 8'h66); set_ch(1, 8'h77); we_i = 2'b11; tick(); we_i = '0; tick(); tick();
      // ch0-only grant moves the pointer to 1, so ch1 wins the next tie
      set_ch(0, 8'h99); we_i = 2'b01; tick(); we_i = '0; tick();
      drain_expect("rot_a", '{8'h55, 8'h66, 8'h77, 8'h99});
      set_ch(0, 8'hAA); set_ch(1, 8'hBB); we_i = 2'b11; tick(); we_i = '0; tick(); tick();
      drain_expect("rot_b", '{8'hBB, 8'hAA});
   endtask

   task automatic test_fill_drop();
      do_reset();
      for (int v = 1; v <= 7; v++) begin
         set_ch(0, DATA_W'(v)); we_i = 2'b01;
         tick();
         n_checks++; if (drop_o[0] !== (v >= 6)) begin
            n_fail++; $display("FAIL fill_drop v=%0d got=%b exp=%b", v, drop_o[0], (v >= 6));
         end
      end
      we_i = '0;
      tick();
      n_checks++; if (full_o !== 1'b1 || count_o !== 3'd4 || busy_o !== 2'b01 || drop_o !== '0) begin
         n_fail++; $display("FAIL fill_state full=%b count=%0d busy=%b drop=%b exp 1/4/01/00", full_o, count_o, busy_o, drop_o);
      end
      n_checks++; if (data_o !== 8'h01) begin n_fail++; $display("FAIL fill_head got=%h exp=01", data_o); end
      // pop while full: the pending grant must wait one cycle
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      n_checks++; if (count_o !== 3'd3 || data_o !== 8'h02 || busy_o !== 2'b01) begin
         n_fail++; $display("FAIL fullpop_block count=%0d data=%h busy=%b exp 3/02/01", count_o, data_o, busy_o);
      end
      tick();
      n_checks++; if (count_o !== 3'd4 || busy_o !== 2'b00 || last_o !== 8'h05) begin
         n_fail++; $display("FAIL fullpop_late count=%0d busy=%b last=%h exp 4/00/05", count_o, busy_o, last_o);
      end
      drain_expect("fill_drain", '{8'h02, 8'h03, 8'h04, 8'h05});
   endtask

   task automatic test_async_reset();
      do_reset();
      set_ch(0, 8'h3C); we_i = 2'b01; tick();
      set_ch(1, 8'h7E); we_i = 2'b10; tick();
      we_i = '0;
      #3;
      reset_i = 1'b1;
      #1;
      m_reset();
      n_checks++; if (valid_o !== 1'b0 || count_o !== '0 || data_o !== '0) begin
         n_fail++; $display("FAIL areset_fifo valid=%b count=%0d data=%h exp 0/0/00", valid_o, count_o, data_o);
      end
      n_checks++; if (busy_o !== '0 || last_o !== '0 || full_o !== 1'b0) begin
         n_fail++; $display("FAIL areset_regs busy=%b last=%h full=%b exp 00/00/0", busy_o, last_o, full_o);
      end
      tick();
      reset_i = 1'b0;
      ready_i = 1'b1;
      set_ch(0, 8'h5A); we_i = 2'b01; tick(); we_i = '0; tick();
      n_checks++; if (valid_o !== 1'b1 || data_o !== 8'h5A) begin
         n_fail++; $display("FAIL areset_fresh valid=%b data=%h exp 1/5a", valid_o, data_o);
      end
      tick();
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_drain valid=%b exp=0", valid_o); end
      ready_i = 1'b0;
   endtask

`ifdef REGDAT_PARITY_EN
   task automatic test_parity();
      do_reset();
      set_ch(0, 8'h07); we_i = 2'b01; tick();
      set_ch(0, 8'h03); tick();
      we_i = '0; tick();
      n_checks++; if (parity_o !== 1'b1 || data_o !== 8'h07) begin
         n_fail++; $display("FAIL parity_07 par=%b data=%h exp 1/07", parity_o, data_o);
      end
      ready_i = 1'b1; tick();
      n_checks++; if (parity_o !== 1'b0 || data_o !== 8'h03) begin
         n_fail++; $display("FAIL parity_03 par=%b data=%h exp 0/03", parity_o, data_o);
      end
      tick();
      n_checks++; if (parity_o !== 1'b0) begin n_fail++; $display("FAIL parity_empty got=%b exp=0", parity_o); end
      ready_i = 1'b0;
   endtask
`endif

   task automatic test_random();
      logic [DATA_W-1:0] exp_head;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         we_i    = N_CH'($urandom_range(0, 3));
         data_i  = (N_CH*DATA_W)'($urandom);
         ready_i = (cyc < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         tick();
         exp_head = (m_q.size() > 0) ? m_q[0] : '0;
         n_checks++; if (valid_o !== (m_q.size() > 0) || data_o !== exp_head) begin
            n_fail++; $display("FAIL rand_head cyc=%0d valid=%b data=%h exp %b/%h", cyc, valid_o, data_o, (m_q.size() > 0), exp_head);
         end
         n_checks++; if (count_o !== CNT_W'(m_q.size()) || full_o !== (m_q.size() == DEPTH)) begin
            n_fail++; $display("FAIL rand_count cyc=%0d count=%0d full=%b exp %0d", cyc, count_o, full_o, m_q.size());
         end
         n_checks++; if (busy_o !== m_busy || drop_o !== m_drop) begin
            n_fail++; $display("FAIL rand_chan cyc=%0d busy=%b drop=%b exp %b/%b", cyc, busy_o, drop_o, m_busy, m_drop);
         end
         n_checks++; if (last_o !== m_last) begin
            n_fail++; $display("FAIL rand_last cyc=%0d got=%h exp=%h", cyc, last_o, m_last);
         end
`ifdef REGDAT_PARITY_EN
         n_checks++; if (parity_o !== ((m_q.size() > 0) ? ^exp_head : 1'b0)) begin
            n_fail++; $display("FAIL rand_parity cyc=%0d got=%b", cyc, parity_o);
         end
`endif
      end
      we_i = '0;
      ready_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1;
      we_i    = '0;
      ready_i = 1'b0;
      data_i  = '0;
      m_reset();
      tick();
      tick();
      reset_i = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_fill_drop();
      test_async_reset();
`ifdef REGDAT_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
